// File: rtl/mem_access_unit_if.sv
// Bundle of the request, RAM and response signals of the MEM-stage access unit.
// The master modport is the access unit; the slave modport is pipeline/RAM side.
interface mem_access_unit_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_load;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [3:0]        req_rd;

    logic              mem_enable;
    logic              mem_rw;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [1:0]        mem_size;
    logic [31:0]       mem_rdata;

    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_data;
    logic [3:0]        resp_rd;
    logic              resp_is_load;
    logic              resp_fault;
    logic              busy;

    modport master (
        input  req_valid, req_load, req_size, req_signed, req_addr, req_wdata, req_rd,
        output req_ready,
        output mem_enable, mem_rw, mem_addr, mem_wdata, mem_size,
        input  mem_rdata,
        output resp_valid, resp_data, resp_rd, resp_is_load, resp_fault,
        input  resp_ready,
        output busy
    );

    modport slave (
        output req_valid, req_load, req_size, req_signed, req_addr, req_wdata, req_rd,
        input  req_ready,
        input  mem_enable, mem_rw, mem_addr, mem_wdata, mem_size,
        output mem_rdata,
        input  resp_valid, resp_data, resp_rd, resp_is_load, resp_fault,
        output resp_ready,
        input  busy
    );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store sequencer for a big-endian byte-addressed RAM that acts on
// Enable transitions: setup cycle, timed Enable pulse, then load extraction.
module mem_access_unit #(
    parameter int MEM_LATENCY = 1,
    parameter int ADDR_W      = 32
) (
    input logic              clk,
    input logic              rst_n,
    mem_access_unit_if.master bus
);
    localparam int LAT   = (MEM_LATENCY < 1) ? 1 : MEM_LATENCY;
    localparam int CNT_W = $clog2(LAT + 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              signed_q;
    logic [ADDR_W-1:0] addr_q;
    logic              fault_req;
    logic [31:0]       load_ext;

    assign bus.req_ready = (state == IDLE);
    assign bus.busy      = (state != IDLE);
    assign bus.mem_addr  = addr_q;

    always_comb begin
        fault_req = 1'b0;
        case (bus.req_size)
            2'b01:   fault_req = bus.req_addr[0];
            2'b10:   fault_req = |bus.req_addr[1:0];
            2'b11:   fault_req = 1'b1;
            default: fault_req = 1'b0;
        endcase
    end

    // RAM returns data right-justified, so extraction only looks at the low bits.
    always_comb begin
        load_ext = bus.mem_rdata;
        case (bus.mem_size)
            2'b00:   load_ext = signed_q ? {{24{bus.mem_rdata[7]}}, bus.mem_rdata[7:0]}
                                         : {24'h0, bus.mem_rdata[7:0]};
            2'b01:   load_ext = signed_q ? {{16{bus.mem_rdata[15]}}, bus.mem_rdata[15:0]}
                                         : {16'h0, bus.mem_rdata[15:0]};
            default: load_ext = bus.mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            cnt              <= '0;
            signed_q         <= 1'b0;
            addr_q           <= '0;
            bus.mem_enable   <= 1'b0;
            bus.mem_rw       <= 1'b0;
            bus.mem_wdata    <= 32'h0;
            bus.mem_size     <= 2'b10;
            bus.resp_valid   <= 1'b0;
            bus.resp_data    <= 32'h0;
            bus.resp_rd      <= 4'h0;
            bus.resp_is_load <= 1'b0;
            bus.resp_fault   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        signed_q         <= bus.req_signed;
                        bus.resp_rd      <= bus.req_rd;
                        bus.resp_is_load <= bus.req_load;
                        bus.resp_data    <= 32'h0;
                        if (fault_req) begin
                            bus.resp_fault <= 1'b1;
                            bus.resp_valid <= 1'b1;
                            state          <= DONE;
                        end else begin
                            bus.resp_fault <= 1'b0;
                            addr_q         <= bus.req_addr;
                            bus.mem_rw     <= ~bus.req_load;
                            bus.mem_size   <= bus.req_size;
                            bus.mem_wdata  <= bus.req_wdata;
                            state          <= SETUP;
                        end
                    end
                end
                SETUP: begin
                    bus.mem_enable <= 1'b1;
                    cnt            <= CNT_W'(LAT - 1);
                    state          <= ACCESS;
                end
                ACCESS: begin
                    if (cnt == '0) begin
                        bus.mem_enable <= 1'b0;
                        bus.resp_valid <= 1'b1;
                        bus.resp_data  <= bus.resp_is_load ? load_ext : 32'h0;
                        state          <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    if (bus.resp_ready) begin
                        bus.resp_valid <= 1'b0;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: a big-endian RAM model, a byte-array
// reference memory, and two units (latency 1 and latency 3).
module tb_mem_access_unit;
    localparam int AW = 32;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  rd;
        logic        is_load;
        logic        fault;
        logic [31:0] addr;
        logic        rw;
        logic [1:0]  size;
        logic [31:0] wdata;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic rst3_n = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic [7:0]  ram     [256];
    logic [7:0]  ref_mem [256];
    exp_t        exp_q[$];
    logic [31:0] rdata1, rdata3;
    logic        wr_prev = 1'b0;
    logic        en_prev = 1'b0;
    int          run1 = 0;

    always #5 clk = ~clk;

    mem_access_unit_if #(.ADDR_W(AW)) if1 ();
    mem_access_unit_if #(.ADDR_W(AW)) if3 ();

    mem_access_unit #(.MEM_LATENCY(1), .ADDR_W(AW)) u_dut1 (.clk(clk), .rst_n(rst_n),  .bus(if1.master));
    mem_access_unit #(.MEM_LATENCY(3), .ADDR_W(AW)) u_dut3 (.clk(clk), .rst_n(rst3_n), .bus(if3.master));

    function automatic int nbytes(logic [1:0] s);
        return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_read(logic [7:0] a, int nb);
        logic [31:0] v = 32'h0;
        for (int i = 0; i < nb; i++) v = {v[23:0], ref_mem[a + 8'(i)]};
        return v;
    endfunction

    task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Big-endian RAM: combinational right-justified read, write on Enable rise.
    always_comb begin
        rdata1 = 32'h0;
        rdata3 = 32'h0;
        for (int i = 0; i < 4; i++) begin
            if (i < nbytes(if1.mem_size)) rdata1 = {rdata1[23:0], ram[if1.mem_addr[7:0] + 8'(i)]};
            if (i < nbytes(if3.mem_size)) rdata3 = {rdata3[23:0], ram[if3.mem_addr[7:0] + 8'(i)]};
        end
    end
    assign if1.mem_rdata = rdata1;
    assign if3.mem_rdata = rdata3;

    always @(negedge clk) begin
        if (if1.mem_enable && !wr_prev && if1.mem_rw) begin
            for (int i = 0; i < nbytes(if1.mem_size); i++)
                ram[if1.mem_addr[7:0] + 8'(i)] <= 8'(if1.mem_wdata >> (8 * (nbytes(if1.mem_size) - 1 - i)));
        end
        wr_prev <= if1.mem_enable;
    end

    // RAM-side protocol monitor: each Enable pulse must match the pending request.
    always @(negedge clk) begin
        if (if1.mem_enable && !en_prev) begin
            checkOutput("queue_depth_at_enable", 32'(exp_q.size()), 32'd1);
            if (exp_q.size() > 0) begin
                if (exp_q[0].fault) checkOutput("enable_rise_on_fault", 32'(if1.mem_enable), 32'd0);
                checkOutput("mem_addr", if1.mem_addr, exp_q[0].addr);
                checkOutput("mem_rw", 32'(if1.mem_rw), 32'(exp_q[0].rw));
                checkOutput("mem_size", 32'(if1.mem_size), 32'(exp_q[0].size));
                if (exp_q[0].rw) checkOutput("mem_wdata", if1.mem_wdata, exp_q[0].wdata);
            end
        end
        if (!if1.mem_enable && en_prev) checkOutput("enable_width", 32'(run1), 32'd1);
        run1    <= if1.mem_enable ? run1 + 1 : 0;
        en_prev <= if1.mem_enable;
    end

    // Response monitor: pops the scoreboard on every response handshake.
    always @(negedge clk) begin
        if (if1.resp_valid && if1.resp_ready) begin
            checkOutput("queue_depth_at_resp", 32'(exp_q.size()), 32'd1);
            if (exp_q.size() > 0) begin
                checkOutput("resp_data", if1.resp_data, exp_q[0].data);
                checkOutput("resp_rd", 32'(if1.resp_rd), 32'(exp_q[0].rd));
                checkOutput("resp_is_load", 32'(if1.resp_is_load), 32'(exp_q[0].is_load));
                checkOutput("resp_fault", 32'(if1.resp_fault), 32'(exp_q[0].fault));
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic applyStimulus(input logic ld, input logic [1:0] size, input logic sgn,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] rd, input int stall);
        exp_t        e;
        int          nb, n, lat;
        logic [31:0] v, held;
        nb        = nbytes(size);
        e.fault   = (size == 2'b11) || (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00);
        e.rd      = rd;
        e.is_load = ld;
        e.addr    = addr;
        e.rw      = !ld;
        e.size    = size;
        e.wdata   = wdata;
        e.data    = 32'h0;
        if (!e.fault && ld) begin
            v = ref_read(addr[7:0], nb);
            if (size == 2'b00)      e.data = sgn ? {{24{v[7]}}, v[7:0]} : {24'h0, v[7:0]};
            else if (size == 2'b01) e.data = sgn ? {{16{v[15]}}, v[15:0]} : {16'h0, v[15:0]};
            else                    e.data = v;
        end else if (!e.fault) begin
            for (int i = 0; i < nb; i++) ref_mem[addr[7:0] + 8'(i)] = 8'(wdata >> (8 * (nb - 1 - i)));
        end
        exp_q.push_back(e);

        n = 0;
        while (!if1.req_ready && n < 50) begin @(posedge clk); #1; n++; end
        checkOutput("req_ready_before_issue", 32'(if1.req_ready), 32'd1);
        if1.req_valid = 1'b1; if1.req_load = ld; if1.req_size = size; if1.req_signed = sgn;
        if1.req_addr = addr; if1.req_wdata = wdata; if1.req_rd = rd;
        @(posedge clk); #1;
        if1.req_valid = 1'b0;
        lat = 1;
        while (!if1.resp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        checkOutput("resp_latency", 32'(lat), e.fault ? 32'd1 : 32'd3);
        held = if1.resp_data;
        repeat (stall) begin
            @(posedge clk); #1;
            checkOutput("stall_resp_valid", 32'(if1.resp_valid), 32'd1);
            checkOutput("stall_resp_data", if1.resp_data, held);
            checkOutput("stall_req_ready", 32'(if1.req_ready), 32'd0);
        end
        if1.resp_ready = 1'b1;
        @(posedge clk); #1;
        if1.resp_ready = 1'b0;
        checkOutput("req_ready_after_hs", 32'(if1.req_ready), 32'd1);
        checkOutput("resp_valid_after_hs", 32'(if1.resp_valid), 32'd0);
    endtask

    task automatic lat3Test();
        int          seen, lat;
        logic [31:0] want;
        if3.req_valid = 1'b1; if3.req_load = 1'b1; if3.req_size = 2'b10;
        if3.req_addr = 32'h80; if3.req_rd = 4'h3;
        @(posedge clk); #1;
        if3.req_valid = 1'b0;
        @(posedge clk); #1;
        checkOutput("lat3_enable_in_access", 32'(if3.mem_enable), 32'd1);
        @(negedge clk);
        rst3_n = 1'b0;
        #1;
        checkOutput("lat3_async_enable_drop", 32'(if3.mem_enable), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst3_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("lat3_req_ready_after_reset", 32'(if3.req_ready), 32'd1);
        checkOutput("lat3_busy_after_reset", 32'(if3.busy), 32'd0);
        seen = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (if3.resp_valid || if3.mem_enable) seen++;
        end
        checkOutput("lat3_no_activity_after_reset", 32'(seen), 32'd0);
        want = ref_read(8'h80, 4);
        if3.req_valid = 1'b1;
        @(posedge clk); #1;
        if3.req_valid = 1'b0;
        lat = 1;
        while (!if3.resp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        checkOutput("lat3_latency", 32'(lat), 32'd5);
        checkOutput("lat3_resp_data", if3.resp_data, want);
        checkOutput("lat3_resp_fault", 32'(if3.resp_fault), 32'd0);
        if3.resp_ready = 1'b1;
        @(posedge clk); #1;
        if3.resp_ready = 1'b0;
        checkOutput("lat3_resp_valid_after_hs", 32'(if3.resp_valid), 32'd0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0]  b;
        logic [1:0]  sz;
        logic [31:0] a;
        for (int i = 0; i < 256; i++) begin
            b = 8'($urandom);
            ram[i]     <= b;
            ref_mem[i]  = b;
        end
        if1.req_valid = 1'b0; if1.req_load = 1'b0; if1.req_size = 2'b00; if1.req_signed = 1'b0;
        if1.req_addr = '0; if1.req_wdata = '0; if1.req_rd = '0; if1.resp_ready = 1'b0;
        if3.req_valid = 1'b0; if3.req_load = 1'b0; if3.req_size = 2'b00; if3.req_signed = 1'b0;
        if3.req_addr = '0; if3.req_wdata = '0; if3.req_rd = '0; if3.resp_ready = 1'b0;
        #2;
        rst_n  = 1'b0;
        rst3_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_mem_enable", 32'(if1.mem_enable), 32'd0);
        checkOutput("reset_mem_size", 32'(if1.mem_size), 32'd2);
        checkOutput("reset_mem_addr", if1.mem_addr, 32'd0);
        checkOutput("reset_resp_valid", 32'(if1.resp_valid), 32'd0);
        checkOutput("reset_resp_data", if1.resp_data, 32'd0);
        checkOutput("reset_req_ready", 32'(if1.req_ready), 32'd1);
        checkOutput("reset_busy", 32'(if1.busy), 32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        rst3_n = 1'b1;
        @(posedge clk); #1;

        applyStimulus(1'b0, 2'b10, 1'b0, 32'd8, 32'hDEADBEEF, 4'h1, 0);
        applyStimulus(1'b1, 2'b10, 1'b0, 32'd8, 32'h0,        4'h2, 0);
        applyStimulus(1'b0, 2'b00, 1'b0, 32'd5, 32'h12345680, 4'h3, 0);
        applyStimulus(1'b1, 2'b00, 1'b1, 32'd5, 32'h0,        4'h4, 0);
        applyStimulus(1'b1, 2'b00, 1'b0, 32'd5, 32'h0,        4'h5, 1);
        applyStimulus(1'b0, 2'b01, 1'b0, 32'd6, 32'hABCD8001, 4'h6, 0);
        applyStimulus(1'b1, 2'b01, 1'b1, 32'd6, 32'h0,        4'h7, 0);
        applyStimulus(1'b1, 2'b01, 1'b0, 32'd6, 32'h0,        4'h8, 2);
        applyStimulus(1'b1, 2'b10, 1'b0, 32'd2, 32'h0,        4'h9, 0);
        applyStimulus(1'b1, 2'b11, 1'b0, 32'd0, 32'h0,        4'hA, 0);
        applyStimulus(1'b0, 2'b01, 1'b0, 32'd7, 32'h5555AAAA, 4'hB, 1);
        applyStimulus(1'b1, 2'b10, 1'b1, 32'd8, 32'h0,        4'hC, 5);

        for (int t = 0; t < 40; t++) begin
            sz = 2'($urandom_range(0, 3));
            a  = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) a = a & ((sz == 2'b10) ? 32'hFC : (sz == 2'b01) ? 32'hFE : 32'hFF);
            applyStimulus(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a,
                          $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3));
        end

        lat3Test();

        repeat (2) @(posedge clk);
        checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
